// File: rtl/img_stream_out_if.sv
// rtl/img_stream_out_if.sv - pixel byte stream with line/frame markers
interface img_stream_out_if;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_sol;
  logic       m_eol;
  logic       m_last;

  modport master (output m_valid, m_data, m_sol, m_eol, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_sol, m_eol, m_last, output m_ready);
endinterface

// File: rtl/img_stream_out.sv
// rtl/img_stream_out.sv - streams the filtered frame out of image SRAM through a 2-entry prefetch FIFO
// Optional frame checksum enabled by defining STREAM_CKSUM_EN.
module img_stream_out #(
  parameter int WIDTH = 256,
  parameter int BASE  = WIDTH * WIDTH
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              cs,
  output logic              we,
  output logic [16:0]       addr,
  input  logic [7:0]        dout,
  img_stream_out_if.master  stream,
  output logic [15:0]       cksum
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] MAXC = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   rx;
  logic [CW-1:0]   ry;
  logic [CW-1:0]   ox;
  logic [CW-1:0]   oy;
  logic            inflight;
  logic [7:0]      fifo_mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      fifo_count;
  logic [16:0]     addr_q;
  logic            done_q;
  logic            pop;
  logic            last_xfer;
  logic            issue;
  logic            accept;
  logic [2:0]      credits_used;
  logic [16:0]     issue_addr;

  assign pop          = stream.m_valid & stream.m_ready;
  assign last_xfer    = pop & stream.m_last;
  // Slots that will be occupied after this cycle: buffered words not leaving now, plus the read in flight.
  assign credits_used = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight};
  assign issue_addr   = 17'(BASE) + 17'({ry, rx});

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        if (credits_used < 3'd2) begin
          issue = 1'b1;
          if (rx == MAXC && ry == MAXC) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx          <= '0;
      ry          <= '0;
      ox          <= '0;
      oy          <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= '0;
      addr_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= (state == DRAIN) && last_xfer;
      inflight   <= issue;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};

      if (accept) begin
        rx <= '0;
        ry <= '0;
        ox <= '0;
        oy <= '0;
      end

      if (issue) begin
        addr_q <= issue_addr;
        if (rx == MAXC) begin
          rx <= '0;
          ry <= ry + CW'(1);
        end else begin
          rx <= rx + CW'(1);
        end
      end

      // SRAM data returns exactly one cycle after the read, so inflight doubles as the push strobe.
      if (inflight) begin
        fifo_mem[wr_ptr] <= dout;
        wr_ptr           <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (ox == MAXC) begin
          ox <= '0;
          oy <= oy + CW'(1);
        end else begin
          ox <= ox + CW'(1);
        end
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;
  assign cs   = issue;
  assign we   = 1'b0;
  assign addr = issue ? issue_addr : addr_q;

  // Tags are gated by valid so the idle/reset bus reads all-zero.
  assign stream.m_valid = (fifo_count != 2'd0);
  assign stream.m_data  = fifo_mem[rd_ptr];
  assign stream.m_sol   = stream.m_valid && (ox == '0);
  assign stream.m_eol   = stream.m_valid && (ox == MAXC);
  assign stream.m_last  = stream.m_eol && (oy == MAXC);

`ifdef STREAM_CKSUM_EN
  logic [15:0] cksum_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cksum_q <= '0;
    end else if (accept) begin
      cksum_q <= '0;
    end else if (pop) begin
      cksum_q <= cksum_q + {8'h00, stream.m_data};
    end
  end

  assign cksum = cksum_q;
`else
  assign cksum = 16'h0000;
`endif

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!n_reset)
    !(inflight && !pop && fifo_count == 2'd2));

endmodule
